// File: rtl/rv32i_decoder_header.sv
// rv32i_decoder_header: shared opcode, branch-code and operand-select constants
package rv32i_decoder_header;
  localparam int ALU_OP_WIDTH = 5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL    = 5'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT    = 5'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU   = 5'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR    = 5'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR     = 5'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND    = 5'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS_B = 5'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 5'd16;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 5'd17;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 5'd18;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 5'd19;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 5'd20;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 5'd21;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM    = 5'd22;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 5'd23;
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_EQ   = 4'd1;
  localparam logic [3:0] ALU_NEQ  = 4'd2;
  localparam logic [3:0] ALU_LT   = 4'd3;
  localparam logic [3:0] ALU_GE   = 4'd4;
  localparam logic [3:0] ALU_LTU  = 4'd5;
  localparam logic [3:0] ALU_GEU  = 4'd6;
  localparam logic [3:0] ALU_JUMP = 4'd7;
  localparam logic ALU_SRC_A_REG = 1'b0;
  localparam logic ALU_SRC_A_PC  = 1'b1;
  localparam logic [1:0] ALU_SRC_B_REG  = 2'd0;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'd1;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'd2;
  localparam logic [1:0] ALU_SRC_B_ZERO = 2'd3;
endpackage

// File: rtl/rv32i_muldiv.sv
// rv32i_muldiv: combinational RV32M multiply/divide, op is the low 3 bits of the ALU opcode
module rv32i_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);
  logic sa, sb, neg_a, neg_b, div_zero;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0] abs_a, abs_b, den, uq, ur, q, r;
  // Signedness per op; divide runs on magnitudes and restores signs afterwards
  always_comb begin
    sa = op[2] ? ~op[0] : (op[1:0] != 2'd3);
    sb = op[2] ? ~op[0] : ~op[1];
    a_ext = {{WIDTH{sa & a[WIDTH-1]}}, a};
    b_ext = {{WIDTH{sb & b[WIDTH-1]}}, b};
    prod = a_ext * b_ext;
    neg_a = sa & a[WIDTH-1];
    neg_b = sb & b[WIDTH-1];
    abs_a = neg_a ? -a : a;
    abs_b = neg_b ? -b : b;
    div_zero = (b == '0);
    den = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
    uq = abs_a / den;
    ur = abs_a % den;
    q = (neg_a ^ neg_b) ? -uq : uq;
    r = neg_a ? -ur : ur;
    result = !op[2] ? ((op[1:0] == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH])
           : op[1] ? (div_zero ? a : r)
           : (div_zero ? '1 : q);
  end
endmodule

// File: rtl/rv32i_alu.sv
// rv32i_alu: execute-stage ALU with operand muxes, branch comparator and registered outputs
module rv32i_alu
  import rv32i_decoder_header::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ALU_OP_WIDTH-1:0] i_alu_op,
  input  logic [3:0]              i_branch_op,
  input  logic                    i_alu_src_a,
  input  logic [1:0]              i_alu_src_b,
  input  logic [WIDTH-1:0]        i_rs1_data,
  input  logic [WIDTH-1:0]        i_rs2_data,
  input  logic [WIDTH-1:0]        i_pc,
  input  logic [WIDTH-1:0]        i_imm,
  output logic [WIDTH-1:0]        o_result,
  output logic                    o_take_branch
);
  logic [WIDTH-1:0] op_a, op_b, base, md_result, result;
  logic [$clog2(WIDTH)-1:0] shamt;
  logic take;
  // Operand selection
  always_comb begin
    op_a = (i_alu_src_a == ALU_SRC_A_PC) ? i_pc : i_rs1_data;
    op_b = (i_alu_src_b == ALU_SRC_B_REG)  ? i_rs2_data
         : (i_alu_src_b == ALU_SRC_B_IMM)  ? i_imm
         : (i_alu_src_b == ALU_SRC_B_FOUR) ? WIDTH'(4)
         : '0;
    shamt = op_b[$clog2(WIDTH)-1:0];
  end
  // Base RV32I operations
  always_comb begin
    base = '0;
    case (i_alu_op)
      ALU_ADD:    base = op_a + op_b;
      ALU_SUB:    base = op_a - op_b;
      ALU_SLL:    base = op_a << shamt;
      ALU_SLT:    base = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   base = {{(WIDTH-1){1'b0}}, op_a < op_b};
      ALU_XOR:    base = op_a ^ op_b;
      ALU_SRL:    base = op_a >> shamt;
      ALU_SRA:    base = $signed(op_a) >>> shamt;
      ALU_OR:     base = op_a | op_b;
      ALU_AND:    base = op_a & op_b;
      ALU_PASS_B: base = op_b;
      default:    base = '0;
    endcase
  end
  rv32i_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .op     (i_alu_op[2:0]),
    .a      (op_a),
    .b      (op_b),
    .result (md_result)
  );
  // Opcodes 16-23 come from the multiply/divide unit; 24-31 are undefined and yield 0
  always_comb result = i_alu_op[4] ? (i_alu_op[3] ? '0 : md_result) : base;
  // Branch condition always compares the raw register values
  always_comb begin
    take = 1'b0;
    case (i_branch_op)
      ALU_EQ:   take = i_rs1_data == i_rs2_data;
      ALU_NEQ:  take = i_rs1_data != i_rs2_data;
      ALU_LT:   take = $signed(i_rs1_data) < $signed(i_rs2_data);
      ALU_GE:   take = $signed(i_rs1_data) >= $signed(i_rs2_data);
      ALU_LTU:  take = i_rs1_data < i_rs2_data;
      ALU_GEU:  take = i_rs1_data >= i_rs2_data;
      ALU_JUMP: take = 1'b1;
      default:  take = 1'b0;
    endcase
  end
  // Output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_result <= '0;
      o_take_branch <= 1'b0;
    end else begin
      o_result <= result;
      o_take_branch <= take;
    end
  end
endmodule

// File: tb/tb_rv32i_alu.sv
// tb_rv32i_alu: scoreboard-driven self-checking bench for rv32i_alu
module tb_rv32i_alu;
  import rv32i_decoder_header::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] i_alu_op = '0;
  logic [3:0] i_branch_op = '0;
  logic i_alu_src_a = 1'b0;
  logic [1:0] i_alu_src_b = '0;
  logic [31:0] i_rs1_data = '0, i_rs2_data = '0, i_pc = '0, i_imm = '0;
  logic [31:0] o_result;
  logic o_take_branch;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    string name;
    logic [4:0] op;
    logic [3:0] bop;
    logic sa;
    logic [1:0] sbs;
    logic [31:0] rs1, rs2, pc, imm, res;
    logic br;
  } vec_t;
  typedef struct {
    string name;
    logic [31:0] res;
    logic br;
  } exp_t;
  vec_t vec_q[$];
  exp_t sb_q[$];
  exp_t e;
  rv32i_alu #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_alu_op      (i_alu_op),
    .i_branch_op   (i_branch_op),
    .i_alu_src_a   (i_alu_src_a),
    .i_alu_src_b   (i_alu_src_b),
    .i_rs1_data    (i_rs1_data),
    .i_rs2_data    (i_rs2_data),
    .i_pc          (i_pc),
    .i_imm         (i_imm),
    .o_result      (o_result),
    .o_take_branch (o_take_branch)
  );
  always #5 clk = ~clk;
  task automatic add(input string name, input logic [4:0] op, input logic [3:0] bop,
                     input logic sa, input logic [1:0] sbs, input logic [31:0] rs1,
                     input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                     input logic [31:0] res, input logic br);
    vec_t v;
    v.name = name; v.op = op; v.bop = bop; v.sa = sa; v.sbs = sbs;
    v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.res = res; v.br = br;
    vec_q.push_back(v);
  endtask
  task automatic drive();
    vec_t v;
    exp_t x;
    v = vec_q.pop_front();
    i_alu_op = v.op; i_branch_op = v.bop; i_alu_src_a = v.sa; i_alu_src_b = v.sbs;
    i_rs1_data = v.rs1; i_rs2_data = v.rs2; i_pc = v.pc; i_imm = v.imm;
    x.name = v.name; x.res = v.res; x.br = v.br;
    sb_q.push_back(x);
  endtask
  task automatic test_reset();
    @(negedge clk);
    i_alu_op = ALU_ADD; i_branch_op = ALU_JUMP; i_rs1_data = 32'd5; i_rs2_data = 32'd6;
    rst = 1'b1;
    #1;
    n_checks++; if (o_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", o_result); end
    n_checks++; if (o_take_branch !== 1'b0) begin n_fail++; $display("FAIL reset_branch: got %b want 0", o_take_branch); end
    @(posedge clk); #1;
    n_checks++; if (o_result !== 32'd0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", o_result); end
    add("reset_release_add", ALU_ADD, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 1, 2, 0, 0, 3, 0);
    @(negedge clk);
    rst = 1'b0;
    drive();
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_checks++; if (o_result !== e.res) begin n_fail++; $display("FAIL %s: result got %h want %h", e.name, o_result, e.res); end
    n_checks++; if (o_take_branch !== e.br) begin n_fail++; $display("FAIL %s: branch got %b want %b", e.name, o_take_branch, e.br); end
  endtask
  task automatic test_arith();
    add("addi", ALU_ADD, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_IMM, 1, 99, 0, 5, 6, 0);
    add("link_pc4", ALU_ADD, ALU_NONE, ALU_SRC_A_PC, ALU_SRC_B_FOUR, 7, 9, 32'h100, 3, 32'h104, 0);
    add("pc_imm", ALU_ADD, ALU_NONE, ALU_SRC_A_PC, ALU_SRC_B_IMM, 7, 9, 32'h100, 32'hFFFF_FFF0, 32'hF0, 0);
    add("lui_pass", ALU_PASS_B, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_IMM, 7, 9, 0, 32'h1234_5000, 32'h1234_5000, 0);
    add("sub_neg", ALU_SUB, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 5, 7, 0, 0, 32'hFFFF_FFFE, 0);
    add("src_b_zero", ALU_ADD, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_ZERO, 9, 5, 0, 5, 9, 0);
    add("and", ALU_AND, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hF0F0, 32'h0FF0, 0, 0, 32'h00F0, 0);
    add("or", ALU_OR, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hF0F0, 32'h0FF0, 0, 0, 32'hFFF0, 0);
    add("xor", ALU_XOR, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hF0F0, 32'h0FF0, 0, 0, 32'hFF00, 0);
    add("undef_op11", 5'd11, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 3, 4, 0, 0, 0, 0);
    add("undef_op24", 5'd24, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 30, 4, 0, 0, 0, 0);
    while (vec_q.size() > 0) begin
      @(negedge clk); drive();
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++; if (o_result !== e.res) begin n_fail++; $display("FAIL %s: result got %h want %h", e.name, o_result, e.res); end
      n_checks++; if (o_take_branch !== e.br) begin n_fail++; $display("FAIL %s: branch got %b want %b", e.name, o_take_branch, e.br); end
    end
  endtask
  task automatic test_branch();
    add("br_eq", ALU_ADD, ALU_EQ, ALU_SRC_A_REG, ALU_SRC_B_REG, 1, 2, 0, 0, 3, 0);
    add("br_neq", ALU_ADD, ALU_NEQ, ALU_SRC_A_REG, ALU_SRC_B_REG, 1, 2, 0, 0, 3, 1);
    add("br_lt", ALU_ADD, ALU_LT, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFFF, 1, 0, 0, 0, 1);
    add("br_ltu", ALU_ADD, ALU_LTU, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    add("br_ge", ALU_ADD, ALU_GE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    add("br_geu", ALU_ADD, ALU_GEU, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFFF, 1, 0, 0, 0, 1);
    add("br_jump", ALU_ADD, ALU_JUMP, ALU_SRC_A_PC, ALU_SRC_B_FOUR, 1, 2, 32'h200, 0, 32'h204, 1);
    add("br_eq_equal", ALU_ADD, ALU_EQ, ALU_SRC_A_REG, ALU_SRC_B_REG, 7, 7, 0, 0, 14, 1);
    add("br_eq_via_pc", ALU_ADD, ALU_EQ, ALU_SRC_A_PC, ALU_SRC_B_IMM, 7, 7, 32'h40, 8, 32'h48, 1);
    add("br_undef9", ALU_ADD, 4'd9, ALU_SRC_A_REG, ALU_SRC_B_REG, 1, 2, 0, 0, 3, 0);
    add("br_undef15", ALU_ADD, 4'd15, ALU_SRC_A_REG, ALU_SRC_B_REG, 2, 2, 0, 0, 4, 0);
    while (vec_q.size() > 0) begin
      @(negedge clk); drive();
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++; if (o_result !== e.res) begin n_fail++; $display("FAIL %s: result got %h want %h", e.name, o_result, e.res); end
      n_checks++; if (o_take_branch !== e.br) begin n_fail++; $display("FAIL %s: branch got %b want %b", e.name, o_take_branch, e.br); end
    end
  endtask
  task automatic test_shift_compare();
    add("sra", ALU_SRA, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_IMM, 32'h8000_0000, 0, 0, 4, 32'hF800_0000, 0);
    add("srl", ALU_SRL, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_IMM, 32'h8000_0000, 0, 0, 4, 32'h0800_0000, 0);
    add("sll31", ALU_SLL, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 1, 31, 0, 0, 32'h8000_0000, 0);
    add("sll_wrap", ALU_SLL, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 1, 33, 0, 0, 2, 0);
    add("slt", ALU_SLT, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFFF, 1, 0, 0, 1, 0);
    add("sltu", ALU_SLTU, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    while (vec_q.size() > 0) begin
      @(negedge clk); drive();
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++; if (o_result !== e.res) begin n_fail++; $display("FAIL %s: result got %h want %h", e.name, o_result, e.res); end
      n_checks++; if (o_take_branch !== e.br) begin n_fail++; $display("FAIL %s: branch got %b want %b", e.name, o_take_branch, e.br); end
    end
  endtask
  task automatic test_muldiv();
    add("mulh_m1", ALU_MULH, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    add("mulhu_max", ALU_MULHU, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 0);
    add("mul_7x6", ALU_MUL, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 7, 6, 0, 0, 42, 0);
    add("mulhsu", ALU_MULHSU, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 0);
    add("mulh_min", ALU_MULH, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h4000_0000, 0);
    add("div_by0", ALU_DIV, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 5, 0, 0, 0, 32'hFFFF_FFFF, 0);
    add("rem_by0", ALU_REM, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 5, 0, 0, 0, 5, 0);
    add("divu_by0", ALU_DIVU, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 5, 0, 0, 0, 32'hFFFF_FFFF, 0);
    add("remu_by0", ALU_REMU, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 5, 0, 0, 0, 5, 0);
    add("div_ovf", ALU_DIV, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000, 0);
    add("rem_ovf", ALU_REM, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    add("div_m7_2", ALU_DIV, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFF9, 2, 0, 0, 32'hFFFF_FFFD, 0);
    add("rem_m7_2", ALU_REM, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFF9, 2, 0, 0, 32'hFFFF_FFFF, 0);
    add("div_7_m2", ALU_DIV, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 7, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFD, 0);
    add("rem_7_m2", ALU_REM, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 7, 32'hFFFF_FFFE, 0, 0, 1, 0);
    add("divu_big", ALU_DIVU, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFF9, 2, 0, 0, 32'h7FFF_FFFC, 0);
    add("remu_big", ALU_REMU, ALU_NONE, ALU_SRC_A_REG, ALU_SRC_B_REG, 32'hFFFF_FFF9, 2, 0, 0, 1, 0);
    while (vec_q.size() > 0) begin
      @(negedge clk); drive();
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++; if (o_result !== e.res) begin n_fail++; $display("FAIL %s: result got %h want %h", e.name, o_result, e.res); end
      n_checks++; if (o_take_branch !== e.br) begin n_fail++; $display("FAIL %s: branch got %b want %b", e.name, o_take_branch, e.br); end
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = (i % 4 == 3) ? a : $urandom;
      case (i % 3)
        0: add("b2b_add", ALU_ADD, ALU_NEQ, ALU_SRC_A_REG, ALU_SRC_B_REG, a, b, 0, 0, a + b, a != b);
        1: add("b2b_sub", ALU_SUB, ALU_EQ, ALU_SRC_A_REG, ALU_SRC_B_REG, a, b, 0, 0, a - b, a == b);
        default: add("b2b_xor", ALU_XOR, ALU_LTU, ALU_SRC_A_REG, ALU_SRC_B_REG, a, b, 0, 0, a ^ b, a < b);
      endcase
    end
    while (vec_q.size() > 0) begin
      @(negedge clk); drive();
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++; if (o_result !== e.res) begin n_fail++; $display("FAIL %s: result got %h want %h", e.name, o_result, e.res); end
      n_checks++; if (o_take_branch !== e.br) begin n_fail++; $display("FAIL %s: branch got %b want %b", e.name, o_take_branch, e.br); end
    end
  endtask
  task automatic test_mid_reset();
    add("pre_reset", ALU_ADD, ALU_JUMP, ALU_SRC_A_REG, ALU_SRC_B_REG, 10, 20, 0, 0, 30, 1);
    while (vec_q.size() > 0) begin
      @(negedge clk); drive();
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_checks++; if (o_result !== e.res) begin n_fail++; $display("FAIL %s: result got %h want %h", e.name, o_result, e.res); end
      n_checks++; if (o_take_branch !== e.br) begin n_fail++; $display("FAIL %s: branch got %b want %b", e.name, o_take_branch, e.br); end
    end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (o_result !== 32'd0) begin n_fail++; $display("FAIL mid_reset_result: got %h want 0", o_result); end
    n_checks++; if (o_take_branch !== 1'b0) begin n_fail++; $display("FAIL mid_reset_branch: got %b want 0", o_take_branch); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (o_result !== 32'd30) begin n_fail++; $display("FAIL post_reset_result: got %h want %h", o_result, 32'd30); end
  endtask
  initial begin
    #1 rst = 1'b1;
    test_reset();
    test_arith();
    test_branch();
    test_shift_compare();
    test_muldiv();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
